// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-approach intersection controller.
// Phase encoding, 7-segment codes (active-low, dp off) and lamp patterns.
package traffic_pkg;

   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALL_RED_1   = 3'd2,
      SIDE_GREEN  = 3'd3,
      SIDE_YELLOW = 3'd4,
      ALL_RED_2   = 3'd5,
      FLASH       = 3'd6
   } state_e;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_OFF    = 3'b000;

endpackage

// File: rtl/seg7_decoder.sv
// Single decimal digit to active-low 7-segment pattern.
// Codes above 9 produce a blank digit.
module seg7_decoder
   import traffic_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Main/side intersection controller with night flash and 2-digit countdown.
// Define TRAFFIC_PED_REQ_EN to enable the pedestrian request latch.
module traffic_intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int CLKS_PER_SEC  = 10_000_000,
   parameter int T_MAIN_GREEN  = 15,
   parameter int T_MAIN_YELLOW = 3,
   parameter int T_SIDE_GREEN  = 10,
   parameter int T_SIDE_YELLOW = 3,
   parameter int T_ALLRED      = 2,
   parameter int PED_SHORTEN   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        night_mode,
   input  logic        ped_req,
   output logic [2:0]  main_rgy,
   output logic [2:0]  side_rgy,
   output logic        ped_walk,
   output logic [15:0] display_led,
   output logic        timer_load,
   output logic [6:0]  timer,
   output logic [2:0]  phase
);

   localparam int CW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_SEC - 1);
   localparam logic [6:0] T_MG  = 7'(T_MAIN_GREEN);
   localparam logic [6:0] T_MY  = 7'(T_MAIN_YELLOW);
   localparam logic [6:0] T_SG  = 7'(T_SIDE_GREEN);
   localparam logic [6:0] T_SY  = 7'(T_SIDE_YELLOW);
   localparam logic [6:0] T_AR  = 7'(T_ALLRED);
   localparam logic [6:0] T_CAP = 7'(PED_SHORTEN);

   logic [CW-1:0] cnt_q, cnt_d;
   state_e        state_q, state_d;
   logic [6:0]    timer_q, timer_d;
   logic          tload_q, tload_d;
   logic          blink_q, blink_d;
   logic          ped_q, ped_d;
   logic          walk_q, walk_d;
   logic          tick;
   logic          ped_set;
   logic [3:0]    tens, units;
   logic [7:0]    seg_t, seg_u;

`ifdef TRAFFIC_PED_REQ_EN
   assign ped_set = ped_q | ped_req;
`else
   logic unused_ped;
   assign unused_ped = ped_req;
   assign ped_set    = ped_q;
`endif

   assign tick  = (cnt_q == CNT_MAX);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         state_q <= ALL_RED_2;
         timer_q <= T_AR;
         tload_q <= 1'b0;
         blink_q <= 1'b0;
         ped_q   <= 1'b0;
         walk_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         timer_q <= timer_d;
         tload_q <= tload_d;
         blink_q <= blink_d;
         ped_q   <= ped_d;
         walk_q  <= walk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      tload_d = 1'b0;
      blink_d = blink_q;
      ped_d   = ped_set;
      walk_d  = walk_q;
      if (tick) begin
         if (state_q == FLASH) begin
            blink_d = ~blink_q;
            if (!night_mode) begin
               state_d = ALL_RED_2;
               timer_d = T_AR;
               tload_d = 1'b1;
            end
         end else if (timer_q > 7'd1) begin
            timer_d = timer_q - 7'd1;
         end else begin
            tload_d = 1'b1;
            case (state_q)
               MAIN_GREEN:  begin state_d = MAIN_YELLOW; timer_d = T_MY; end
               MAIN_YELLOW: begin state_d = ALL_RED_1;   timer_d = T_AR; end
               ALL_RED_1:   begin state_d = SIDE_GREEN;  timer_d = T_SG; end
               SIDE_GREEN:  begin state_d = SIDE_YELLOW; timer_d = T_SY; end
               SIDE_YELLOW: begin state_d = ALL_RED_2;   timer_d = T_AR; end
               default:     begin state_d = MAIN_GREEN;  timer_d = T_MG; end
            endcase
            // Night request only takes effect at the end of a clearance phase
            if ((state_q == ALL_RED_1 || state_q == ALL_RED_2) && night_mode) begin
               state_d = FLASH;
               timer_d = 7'd0;
               blink_d = 1'b1;
            end
         end
      end
      if (state_q == MAIN_GREEN && state_d == MAIN_GREEN
          && ped_set && timer_q > T_CAP)
         timer_d = T_CAP;
      if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) begin
         walk_d = ped_set;
         ped_d  = 1'b0;
      end else if (state_d != SIDE_GREEN) begin
         walk_d = 1'b0;
      end
   end

   always_comb begin
      main_rgy = LAMP_RED;
      side_rgy = LAMP_RED;
      case (state_q)
         MAIN_GREEN:  main_rgy = LAMP_GREEN;
         MAIN_YELLOW: main_rgy = LAMP_YELLOW;
         SIDE_GREEN:  side_rgy = LAMP_GREEN;
         SIDE_YELLOW: side_rgy = LAMP_YELLOW;
         FLASH: begin
            main_rgy = blink_q ? LAMP_YELLOW : LAMP_OFF;
            side_rgy = blink_q ? LAMP_RED : LAMP_OFF;
         end
         default: ;
      endcase
   end

   assign tens  = 4'(timer_q / 7'd10);
   assign units = 4'(timer_q % 7'd10);

   seg7_decoder u_seg_tens (.digit_i(tens),  .seg_o(seg_t));
   seg7_decoder u_seg_units(.digit_i(units), .seg_o(seg_u));

   assign display_led = (state_q == FLASH) ? {SEG_BLANK, SEG_BLANK}
                                           : {seg_t, seg_u};
   assign timer_load  = tload_q;
   assign timer       = timer_q;
   assign phase       = state_q;
   assign ped_walk    = walk_q;

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Two-approach (main/side) intersection controller; the successor to the single-approach traffic light.
- Phase durations, clock rate and all-red clearance are parameters.
- Adds a night flashing mode and an optional pedestrian request.
- Drives lamp outputs for both approaches, plus a 2-digit active-low 7-segment countdown of the current phase's remaining seconds and the timer_load/timer debug outputs.

Parameters:
CLKS_PER_SEC, 10_000_000, clk cycles per 1 s tick (>=2)
T_MAIN_GREEN, 15, main green seconds (1..99)
T_MAIN_YELLOW, 3, main yellow seconds (1..99)
T_SIDE_GREEN, 10, side green seconds (1..99)
T_SIDE_YELLOW, 3, side yellow seconds (1..99)
T_ALLRED, 2, all-red clearance seconds (1..99)
PED_SHORTEN, 5, main-green remaining cap on pedestrian request (1..99)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
night_mode  in  1  request flashing mode (level)
ped_req  in  1  pedestrian button (pulse or level)
main_rgy  out  3  {red,yellow,green} main approach
side_rgy  out  3  {red,yellow,green} side approach
ped_walk  out  1  walk lamp
display_led  out  16  [15:8] tens digit, [7:0] units digit, active-low segments, bit7 = dp (always 1)
timer_load  out  1  one-cycle pulse in the first cycle of every new phase
timer  out  7  remaining seconds of the current phase
phase  out  3  current state encoding

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst; it has priority over everything.
- Prescaler counts 0..CLKS_PER_SEC-1; `tick` = 1 in the cycle it wraps. Reset clears it.
- States and entry values:
  - MAIN_GREEN: T_MAIN_GREEN
  - MAIN_YELLOW: T_MAIN_YELLOW
  - ALL_RED_1: T_ALLRED
  - SIDE_GREEN: T_SIDE_GREEN
  - SIDE_YELLOW: T_SIDE_YELLOW
  - ALL_RED_2: T_ALLRED
  - FLASH: no countdown
- Countdown: on tick, if timer > 1 then timer - 1; if timer == 1, transition and load the next state's value. timer never reaches 0 outside FLASH.
- Sequence: ALL_RED_2 -> MAIN_GREEN -> MAIN_YELLOW -> ALL_RED_1 -> SIDE_GREEN -> SIDE_YELLOW -> ALL_RED_2.
- Night mode:
  - Sampled only on expiry of ALL_RED_1 or ALL_RED_2. If high there, next state is FLASH.
  - FLASH: main_rgy = {0,blink,0}, side_rgy = {blink,0,0}. blink toggles on every tick and is 1 on entry. timer = 0; display_led = 16'hFFFF (blank).
  - On a tick with night_mode low, FLASH -> ALL_RED_2.
- Lamps:
  - The approach not in green/yellow shows red.
  - Exactly one lamp per approach is lit outside FLASH.
  - Both approaches red in ALL_RED_*.
  - main is never green/yellow while side is green/yellow.
- Display: timer split into tens = timer/10 and units = timer%10. Encoding 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90; default FF.
- Lamps and display are combinational from registered state/timer/blink only.
- timer_load is registered. It is high exactly one cycle, in the first cycle of each new state, including FLASH entry.
- Reset values:
  - State registers: state = ALL_RED_2, timer = T_ALLRED, timer_load = 0, blink = 0, ped latch = 0.
  - Outputs: main_rgy = side_rgy = 3'b100, ped_walk = 0, display shows T_ALLRED.
- Reset mid-phase: the next cycle is the reset state; no partial countdown is retained.

Optional Feature:
Macro TRAFFIC_PED_REQ_EN.
- With the macro:
  - ped_req sets a latch.
  - While latched in MAIN_GREEN with timer > PED_SHORTEN, timer is forced to PED_SHORTEN on the next cycle (no timer_load pulse).
  - The latch clears on entry to SIDE_GREEN.
  - ped_walk = 1 throughout any SIDE_GREEN entered with the latch set.
  - In FLASH, requests are held.
- Without the macro: ped_req is ignored and ped_walk is tied 0. Ports remain.

Decomposition:
- Package traffic_pkg holds:
  - the state enum (3-bit)
  - segment constants SEG_0..SEG_9 and SEG_BLANK
  - lamp constants LAMP_RED/YELLOW/GREEN/OFF
- One sub-module, seg7_decoder: 4-bit digit in, 8-bit active-low segments out. It is instantiated twice.

Test Plan:
1. CLKS_PER_SEC=4. Release rst -> display 16'hC0A4 ("02"), both red. After 8 clks: MAIN_GREEN, timer = 15, timer_load high 1 cycle, main_rgy = 001, side_rgy = 100.
2. Run a full cycle. Each phase lasts exactly (duration × 4) clks; total 35 s = 140 clks between successive MAIN_GREEN entries. Lamp mutual exclusion is checked every cycle.
3. Raise night_mode during MAIN_GREEN. Required: no change until ALL_RED_1 expires, then FLASH, display FFFF, main yellow toggling every 4 clks. Drop night_mode -> ALL_RED_2 (timer 2) -> MAIN_GREEN.
4. Assert rst for 1 cycle mid SIDE_GREEN (timer 6). Required next cycle: ALL_RED_2, timer = 2, prescaler 0, ped latch 0.
5. With TRAFFIC_PED_REQ_EN: pulse ped_req at MAIN_GREEN timer = 12 -> timer = 5 next cycle. At timer = 3, a pulse changes nothing. ped_walk = 1 for all 40 clks of SIDE_GREEN. Without the macro, timer continues 12, 11, ….
6. Display check: timer = 9 -> 16'hC090; timer = 15 -> 16'hF992; timer = 10 -> 16'hF9C0.
